// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// No logic; elaboration-time constants only.
// Not applicable (no handshakes in a package).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

    // Bit-counter width: enough to index WIDTH bits, never narrower than one flop.
    function automatic int cnt_w(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder: {cout,sum} = a + b + cin.
// Purely combinational, zero cycles.
// No handshakes; the caller decides when the result is consumed.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {1'b0, cin};

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, registered carry.
// Latency: accept on edge k, out_valid from edge k+WIDTH; op-to-op interval WIDTH+2.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Optional self-check (capture regs + deferred assertions): SERIAL_ADDER_CHECK_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    sa_state_t        r_state;
    sa_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic             w_shift;
    logic             w_cell_sum;
    logic             w_cell_cout;

    full_adder_cell u_cell (
        .a    (r_sh_a[0]),
        .b    (r_sh_b[0]),
        .cin  (r_carry),
        .sum  (w_cell_sum),
        .cout (w_cell_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_result_nxt = w_cell_sum;
        end else begin : g_wn
            assign w_result_nxt = {w_cell_sum, r_result[WIDTH-1:1]};
        end
    endgenerate

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then consume one bit per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_sh_a   <= a;
            r_sh_b   <= b;
            r_result <= '0;
            r_carry  <= cin;
            r_cnt    <= '0;
        end else if (w_shift) begin
            r_sh_a   <= r_sh_a >> 1;
            r_sh_b   <= r_sh_b >> 1;
            r_result <= w_result_nxt;
            r_carry  <= w_cell_cout;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Result is left in place after the handshake; out_valid alone qualifies it.
    assign sum  = r_result;
    assign cout = r_carry;

`ifdef SERIAL_ADDER_CHECK_EN
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic             r_cap_cin;
    logic [WIDTH:0]   w_ref;

    // Snapshot of the accepted operands, used only by the checks below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_a   <= '0;
            r_cap_b   <= '0;
            r_cap_cin <= 1'b0;
        end else if (w_load) begin
            r_cap_a   <= a;
            r_cap_b   <= b;
            r_cap_cin <= cin;
        end
    end

    assign w_ref = {1'b0, r_cap_a} + {1'b0, r_cap_b} + {{WIDTH{1'b0}}, r_cap_cin};

    // Cell truth-table check on every consumed bit.
    always_comb begin
        if (!rst && r_state == SHIFT) begin
            assert #0 ((w_cell_sum == (r_sh_a[0] ^ r_sh_b[0] ^ r_carry)) &&
                       (w_cell_cout == ((r_sh_a[0] & r_sh_b[0]) | (r_sh_a[0] & r_carry) |
                                        (r_sh_b[0] & r_carry))))
            else $error("serial_adder cell error at %0t: a=%0h b=%0h cin=%0b",
                        $time, r_cap_a, r_cap_b, r_cap_cin);
        end
    end

    // Whole-word check while the result is presented.
    always_comb begin
        if (!rst && r_state == DONE) begin
            assert #0 ({cout, sum} == w_ref)
            else $error("serial_adder word error at %0t: a=%0h b=%0h cin=%0b got=%0h",
                        $time, r_cap_a, r_cap_b, r_cap_cin, {cout, sum});
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        int         stall;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Full WIDTH=8 operation, entered and left on a falling edge.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [8:0] exp, input int stall, input logic junk);
        int j;
        int bad;
        logic [8:0] e;
        chk("in_ready_idle8", {31'b0, in_ready8}, 32'd1);
        in_valid8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        q8.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = junk;
        a8 = junk ? 8'h11 : 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom);
        j = 0; bad = 0;
        while (!out_valid8 && j < 64) begin
            if (in_ready8 !== 1'b0) bad++;
            @(posedge clk);
            @(negedge clk);
            j++;
        end
        chk("latency8", j, 32'd8);
        chk("in_ready_busy8", bad, 32'd0);
        e = (q8.size() > 0) ? q8[0] : 9'h1FF;
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid8", {31'b0, out_valid8}, 32'd1);
            chk("stall_data8", {23'b0, cout8, sum8}, {23'b0, e});
            chk("stall_in_ready8", {31'b0, in_ready8}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("result8", {23'b0, cout8, sum8}, {23'b0, e});
        if (q8.size() > 0) void'(q8.pop_front());
        out_ready8 = 1'b1;
        in_valid8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("valid_drop8", {31'b0, out_valid8}, 32'd0);
        chk("back_idle8", {31'b0, in_ready8}, 32'd1);
        chk("sum_kept8", {23'b0, cout8, sum8}, {23'b0, e});
    endtask

    task automatic op1(input logic ta, input logic tb, input logic tc);
        int j;
        logic [1:0] e;
        chk("in_ready_idle1", {31'b0, in_ready1}, 32'd1);
        in_valid1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
        q1.push_back({1'b0, ta} + {1'b0, tb} + {1'b0, tc});
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0; a1 = ~ta; b1 = ~tb; cin1 = ~tc;
        j = 0;
        while (!out_valid1 && j < 16) begin
            @(posedge clk);
            @(negedge clk);
            j++;
        end
        chk("latency1", j, 32'd1);
        e = (q1.size() > 0) ? q1.pop_front() : 2'b11;
        chk("result1", {30'b0, cout1, sum1}, {30'b0, e});
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("valid_drop1", {31'b0, out_valid1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 2, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 1, 8'h01, 1'b0};
        tbl[6] = '{8'hAA, 8'h55, 1'b1, 0, 8'h00, 1'b1};
        tbl[7] = '{8'h7F, 8'h01, 1'b0, 3, 8'h80, 1'b0};

        rst = 1'b1;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        #1;
        chk("rst_in_ready8", {31'b0, in_ready8}, 32'd1);
        chk("rst_out_valid8", {31'b0, out_valid8}, 32'd0);
        chk("rst_sum8", {23'b0, cout8, sum8}, 32'd0);
        chk("rst_in_ready1", {31'b0, in_ready1}, 32'd1);
        chk("rst_out1", {30'b0, out_valid1, sum1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            op8(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].sum}, tbl[i].stall, 1'b0);

        // Backpressure with a competing operand that must be ignored.
        op8(8'h3C, 8'h42, 1'b0, 9'h07E, 5, 1'b1);
        op8(8'h01, 8'h02, 1'b0, 9'h003, 0, 1'b0);

        // Asynchronous reset during the third shift cycle.
        in_valid8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1;
        q8.push_back(9'h078);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid8}, 32'd0);
        chk("arst_sum", {23'b0, cout8, sum8}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready8}, 32'd1);
        #1 rst = 1'b0;
        void'(q8.pop_front());
        @(negedge clk);
        chk("post_arst_idle", {31'b0, in_ready8}, 32'd1);
        op8(8'h55, 8'hAA, 1'b0, 9'h0FF, 0, 1'b0);

        // Random operands and stalls against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            op8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'b0, rc}, $urandom_range(0, 3), 1'b0);
        end

        // WIDTH=1: every operand combination.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            op1(v[2], v[1], v[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
